// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared axis state type and default 640x480@60 timing constants
package vga_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } axis_state_e;

    localparam int POS_W = 10;

    localparam int VGA_CLK_DIV  = 4;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

endpackage

// File: rtl/vga_axis_timer.sv
// rtl/vga_axis_timer.sv - one raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK FSM
module vga_axis_timer
    import vga_pkg::*;
#(
    parameter int ACT  = VGA_H_ACTIVE,
    parameter int FP   = VGA_H_FP,
    parameter int SYNC = VGA_H_SYNC,
    parameter int BP   = VGA_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [POS_W-1:0] pos,
    output axis_state_e      state,
    output logic             wrap,
    output logic             sync_on,
    output logic             act_on
);

    localparam int               TOTAL       = ACT + FP + SYNC + BP;
    localparam logic [POS_W-1:0] LAST        = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] FRONT_START = POS_W'(ACT);
    localparam logic [POS_W-1:0] SYNC_START  = POS_W'(ACT + FP);
    localparam logic [POS_W-1:0] BACK_START  = POS_W'(ACT + FP + SYNC);

    logic [POS_W-1:0] pos_q, pos_d;
    axis_state_e      state_q, state_d;

    assign wrap = (pos_q == LAST);

    always_comb begin
        pos_d   = pos_q;
        state_d = state_q;
        if (en) begin
            if (wrap) begin
                pos_d   = '0;
                state_d = ST_ACTIVE;
            end else begin
                pos_d = pos_q + POS_W'(1);
                case (state_q)
                    ST_ACTIVE: if (pos_d == FRONT_START) state_d = ST_FRONT;
                    ST_FRONT:  if (pos_d == SYNC_START)  state_d = ST_SYNC;
                    ST_SYNC:   if (pos_d == BACK_START)  state_d = ST_BACK;
                    default:   state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q   <= LAST;
            state_q <= ST_BACK;
        end else begin
            pos_q   <= pos_d;
            state_q <= state_d;
        end
    end

    assign pos   = pos_q;
    assign state = state_q;

    // Decoded from the next state so the parent can register them alongside pos.
    assign sync_on = (state_d == ST_SYNC);
    assign act_on  = (state_d == ST_ACTIVE);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel divider, h/v axis timers, registered sync/video/frame tick
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pixel_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [POS_W-1:0] pixel_x,
    output logic [POS_W-1:0] pixel_y,
    output logic             tick60HZ
);

    localparam logic [3:0]       DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [POS_W-1:0] V_LAST_ACTIVE = POS_W'(V_ACTIVE - 1);

    logic [3:0] div_q, div_d;
    logic       hsync_q, vsync_q, video_q, tick_q, tick_d;
    logic       h_wrap, v_wrap, v_en;
    logic       h_sync_on, v_sync_on, h_act_on, v_act_on;
    logic [POS_W-1:0] h_pos, v_pos;
    axis_state_e      h_state, v_state;

    // With CLK_DIV = 1 div stays at 0 and the decode is permanently true.
    assign pixel_tick = (div_q == DIV_LAST);
    assign div_d      = pixel_tick ? 4'd0 : div_q + 4'd1;
    assign v_en       = pixel_tick & h_wrap;

    vga_axis_timer #(
        .ACT (H_ACTIVE),
        .FP  (H_FP),
        .SYNC(H_SYNC),
        .BP  (H_BP)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .en     (pixel_tick),
        .pos    (h_pos),
        .state  (h_state),
        .wrap   (h_wrap),
        .sync_on(h_sync_on),
        .act_on (h_act_on)
    );

    vga_axis_timer #(
        .ACT (V_ACTIVE),
        .FP  (V_FP),
        .SYNC(V_SYNC),
        .BP  (V_BP)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .en     (v_en),
        .pos    (v_pos),
        .state  (v_state),
        .wrap   (v_wrap),
        .sync_on(v_sync_on),
        .act_on (v_act_on)
    );

    logic unused_axis;
    assign unused_axis = ^{h_state, v_state, v_wrap};

    // Fires on the edge that moves the raster onto the first blanking line.
    assign tick_d = v_en & (v_pos == V_LAST_ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= 4'd0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            video_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            hsync_q <= h_sync_on ~^ SYNC_POL;
            vsync_q <= v_sync_on ~^ SYNC_POL;
            video_q <= h_act_on & v_act_on;
            tick_q  <= tick_d;
        end
    end

    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign video_on = video_q;
    assign tick60HZ = tick_q;
    assign pixel_x  = h_pos;
    assign pixel_y  = v_pos;

endmodule
